// File: rtl/s208_pkg.sv
// Shared constants and types for the s208 rate-multiplier receive path.
package s208_pkg;
    localparam int WIN_BITS_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;
endpackage

// File: rtl/s208_rate_decoder_if.sv
// Result/handshake bundle between a strobe source, the decoder and its consumer.
interface s208_rate_decoder_if
    import s208_pkg::*;
#(
    parameter int WIN_BITS = WIN_BITS_DEF
);
    logic                X;
    logic                Z;
    logic                Ack;
    logic [WIN_BITS:0]   C;
    logic                Valid;
    logic                W;
    logic                Ovr;

    modport master (output X, Z, Ack, input C, Valid, W, Ovr);
    modport slave  (input X, Z, Ack, output C, Valid, W, Ovr);
endinterface

// File: rtl/s208_win_cnt.sv
// Window step counter; TC flags the strobe that closes a 2^WIN_BITS window.
module s208_win_cnt
    import s208_pkg::*;
#(
    parameter int WIN_BITS = WIN_BITS_DEF
) (
    input  logic CK,
    input  logic Clear,
    input  logic X,
    output logic TC
);
    logic [WIN_BITS-1:0] cnt;

    always_ff @(posedge CK) begin
        if (Clear)
            cnt <= '0;
        else if (X)
            cnt <= cnt + WIN_BITS'(1);
    end

    assign TC = X && (cnt == '1);
endmodule

// File: rtl/s208_rate_decoder.sv
// Measures Z pulse density over 2^WIN_BITS X strobes and holds the result under valid/ack.
module s208_rate_decoder
    import s208_pkg::*;
#(
    parameter int WIN_BITS = WIN_BITS_DEF
) (
    input  logic                CK,
    input  logic                Clear,
    input  logic                X,
    input  logic                Z,
    input  logic                Ack,
    output logic [WIN_BITS:0]   C,
    output logic                Valid,
    output logic                W,
    output logic                Ovr
);
    logic              tc;
    logic [WIN_BITS:0] acc;
    logic [WIN_BITS:0] z_ext;
    hold_state_t       state_q, state_d;

    s208_win_cnt #(.WIN_BITS(WIN_BITS)) u_win_cnt (
        .CK    (CK),
        .Clear (Clear),
        .X     (X),
        .TC    (tc)
    );

    assign z_ext = {{WIN_BITS{1'b0}}, Z};

    always_ff @(posedge CK) begin
        if (Clear) begin
            acc <= '0;
            C   <= '0;
            W   <= 1'b0;
            Ovr <= 1'b0;
        end else begin
            W <= tc;
            if (tc) begin
                // Final strobe's own Z is folded in here, not in acc.
                C   <= acc + z_ext;
                acc <= '0;
                if (state_q == FULL && !Ack)
                    Ovr <= 1'b1;
            end else if (X) begin
                acc <= acc + z_ext;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (Clear)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (tc) state_d = FULL;
            FULL:  if (!tc && Ack) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign Valid = (state_q == FULL);
endmodule

// File: tb/tb_s208_rate_decoder.sv
// Directed + random stimulus for s208_rate_decoder against a strobe-counting reference model.
module tb_s208_rate_decoder;
    import s208_pkg::*;

    localparam int WB  = WIN_BITS_DEF;
    localparam int WIN = 1 << WB;

    logic CK;
    logic Clear;
    s208_rate_decoder_if #(.WIN_BITS(WB)) bus ();

    s208_rate_decoder #(.WIN_BITS(WB)) dut (
        .CK    (CK),
        .Clear (Clear),
        .X     (bus.X),
        .Z     (bus.Z),
        .Ack   (bus.Ack),
        .C     (bus.C),
        .Valid (bus.Valid),
        .W     (bus.W),
        .Ovr   (bus.Ovr)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int tests = 0;
    int fails = 0;

    // Reference model: total strobes since Clear, pulses in the open window, held result.
    int   m_strobes;
    int   m_pulses;
    int   m_c;
    bit   m_v, m_w, m_o;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".C"},     int'(bus.C),     m_c);
        chk({tag, ".Valid"}, int'(bus.Valid), int'(m_v));
        chk({tag, ".W"},     int'(bus.W),     int'(m_w));
        chk({tag, ".Ovr"},   int'(bus.Ovr),   int'(m_o));
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic cyc(input string tag, input bit clr, input bit x, input bit z, input bit ack);
        bit win_end;
        Clear   = clr;
        bus.X   = x;
        bus.Z   = z;
        bus.Ack = ack;
        if (clr) begin
            m_strobes = 0; m_pulses = 0; m_c = 0;
            m_v = 0; m_w = 0; m_o = 0;
        end else begin
            win_end = x && ((m_strobes % WIN) == WIN - 1);
            m_w = win_end;
            if (x) begin
                m_pulses += int'(z);
                m_strobes++;
            end
            if (win_end) begin
                m_c = m_pulses;
                m_pulses = 0;
                if (m_v && !ack) m_o = 1;
                m_v = 1;
            end else if (ack) begin
                m_v = 0;
            end
        end
        @(posedge CK);
        @(negedge CK);
        chk_all(tag);
    endtask

    initial begin
        Clear = 1'b1; bus.X = 0; bus.Z = 0; bus.Ack = 0;
        m_strobes = 0; m_pulses = 0; m_c = 0; m_v = 0; m_w = 0; m_o = 0;
        @(negedge CK);

        // Reset state, with Clear overriding active X/Z/Ack
        cyc("reset", 1, 1, 1, 1);
        chk("reset.C0", int'(bus.C), 0);
        chk("reset.V0", int'(bus.Valid), 0);

        // Full-density window
        for (int i = 0; i < WIN; i++) cyc("full", 0, 1, 1, 0);
        chk("full.C", int'(bus.C), 'h100);
        chk("full.W", int'(bus.W), 1);
        chk("full.V", int'(bus.Valid), 1);
        cyc("full_idle", 0, 0, 1, 0);
        chk("full.Wpulse", int'(bus.W), 0);
        cyc("ack", 0, 0, 0, 1);
        chk("ack.V", int'(bus.Valid), 0);

        // Ack while empty is a no-op
        cyc("ack_empty", 0, 0, 0, 1);
        chk("ack_empty.C", int'(bus.C), 'h100);

        // Half density with X=0 gaps carrying junk Z
        for (int i = 0; i < WIN; i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) cyc("half_gap", 0, 0, 1'($urandom), 0);
            cyc("half", 0, 1, (i % 2) == 0, 0);
        end
        chk("half.C", int'(bus.C), 'h080);
        cyc("half_ack", 0, 0, 0, 1);

        // Overrun: two windows, no ack
        cyc("clr_ovr", 1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) cyc("ovr_w0", 0, 1, 0, 0);
        chk("ovr.first_ovr", int'(bus.Ovr), 0);
        for (int i = 0; i < WIN; i++) cyc("ovr_w1", 0, 1, 1, 0);
        chk("ovr.C", int'(bus.C), 'h100);
        chk("ovr.V", int'(bus.Valid), 1);
        chk("ovr.O", int'(bus.Ovr), 1);
        for (int i = 0; i < 5; i++) cyc("ovr_sticky", 0, 0, 0, 1);
        chk("ovr.sticky", int'(bus.Ovr), 1);

        // Ack coincident with window end
        cyc("clr_coinc", 1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) cyc("coinc_w0", 0, 1, 0, 0);
        for (int i = 0; i < WIN; i++) cyc("coinc_w1", 0, 1, i < 37, i == WIN - 1);
        chk("coinc.V", int'(bus.Valid), 1);
        chk("coinc.C", int'(bus.C), 37);
        chk("coinc.O", int'(bus.Ovr), 0);
        cyc("coinc_ack", 0, 0, 0, 1);
        chk("coinc.Vdrop", int'(bus.Valid), 0);

        // Mid-window Clear discards the partial window
        cyc("clr_part", 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) cyc("part", 0, 1, 1, 0);
        cyc("clr_mid", 1, 1, 1, 0);
        for (int i = 0; i < WIN - 1; i++) cyc("post_clr", 0, 1, 0, 0);
        chk("post_clr.noV", int'(bus.Valid), 0);
        cyc("post_clr_end", 0, 1, 0, 0);
        chk("post_clr.C", int'(bus.C), 0);
        chk("post_clr.V", int'(bus.Valid), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc("rand", ($urandom_range(0, 999) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom), ($urandom_range(0, 199) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/s208_rate_decoder.md
S208_RATE_DECODER -- requirements
Module: s208_rate_decoder

Purpose: receive end of the s208 rate-multiplier pulse stream. Counts Z pulses over a window of 2^WIN_BITS X strobes and presents the measured density with a valid/ack handshake.

Interface
REQ-001 The block SHALL have parameter WIN_BITS, default 8: log2 of the window length in X strobes.
REQ-002 The block SHALL have port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Clear, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port X, input, 1 bit: step strobe; one window step per CK cycle with X=1.
REQ-005 The block SHALL have port Z, input, 1 bit: pulse stream; sampled only in cycles with X=1.
REQ-006 The block SHALL have port Ack, input, 1 bit: consumer accepts the held result.
REQ-007 The block SHALL have port C, output, WIN_BITS+1 bits: measured pulse count of the last completed window.
REQ-008 The block SHALL have port Valid, output, 1 bit: C holds an unacknowledged result.
REQ-009 The block SHALL have port W, output, 1 bit: one-cycle window-end pulse.
REQ-010 The block SHALL have port Ovr, output, 1 bit: sticky overrun flag.

Function
REQ-011 The block SHALL keep a WIN_BITS-bit window counter, incremented modulo 2^WIN_BITS on every cycle with X=1, and unchanged when X=0.
REQ-012 The block SHALL keep a (WIN_BITS+1)-bit accumulator, incremented in every cycle with X=1 and Z=1; it cannot overflow (maximum 2^WIN_BITS).
REQ-013 In a cycle with X=1 and window counter = 2^WIN_BITS-1, the block SHALL compute the final value as accumulator+Z, and at the next edge load it into C, set Valid=1, pulse W=1 for exactly one cycle, and zero the accumulator.
REQ-014 Latency from the last X strobe of a window to Valid/W SHALL be exactly 1 cycle.
REQ-015 The output holder SHALL be a two-state FSM. EMPTY (Valid=0) moves to FULL on a window end. FULL moves to EMPTY on Ack=1 with no window end in the same cycle. FULL stays FULL on a window end.
REQ-016 C SHALL be stable while Valid=1, except when it is overwritten by a new window end.
REQ-017 An Ack asserted while Valid=0 SHALL be ignored.
REQ-018 When Ack=1 and a window end occur in the same cycle, the new result SHALL load, Valid SHALL stay 1, and Ovr SHALL NOT be set.
REQ-019 When a window end occurs with Valid=1 and Ack=0, C SHALL be overwritten and Ovr SHALL be set to 1; Ovr stays set until Clear.
REQ-020 When X=0, the window counter and accumulator SHALL hold regardless of Z.

Reset
REQ-021 When Clear=1 at a rising edge of CK, the block SHALL set window counter=0, accumulator=0, C=0, Valid=0, W=0, Ovr=0, FSM=EMPTY.
REQ-022 Clear SHALL take priority over X, Z and Ack in the same cycle.
REQ-023 After a Clear asserted mid-window, the partial window SHALL be discarded and the first full window SHALL start at the first X strobe after Clear deasserts.

Structure
REQ-024 Package s208_pkg SHALL hold WIN_BITS_DEF=8 and the FSM state enum {EMPTY, FULL}.
REQ-025 The window counter plus terminal-count detect SHALL be sub-module s208_win_cnt, with ports CK, Clear, X and TC.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-027 Test: Clear, then 256 cycles with X=1 and Z=1 -> one cycle later C=0x100, Valid=1 and W=1 for one cycle.
REQ-028 Test: 256 X strobes with Z=1 on even strobes only, with X=0 gaps in between -> C=0x080; Z toggling during X=0 cycles has no effect.
REQ-029 Test: two windows with Z=0 and then Z=1, no Ack -> after the second window C=0x100, Valid=1, Ovr=1.
REQ-030 Test: Ack asserted in the same cycle as the window-end strobe -> Valid stays 1, C is updated, Ovr=0; Ack in the following cycle -> Valid=0.
REQ-031 Test: Clear asserted after 100 strobes with Z=1, then 256 strobes with Z=0 -> C=0x000; no result appears from the discarded partial window.
REQ-032 Test: Ack with Valid=0 -> no change in state or outputs.
